// File: rtl/flash_dma_ctrl.sv
// flash_dma_ctrl: flash-to-RAM DMA engine with boot IPL copy and word-interleaved CPU flash reads
//   cpu  : i_cpu_addr/i_cpu_rd_valid in, o_cpu_rd_ready pulse, o_cpu_rdata held
//   cfg  : i_cfg_src/i_cfg_dst/i_cfg_len latched on i_cfg_start while idle; o_dma_busy, o_dma_done pulse
//   ram  : o_wr_addr/o_wr_data/o_wr_strobe held until i_wr_ready
//   flash: o_fl_valid/o_fl_continue/o_fl_addr request, i_fl_ready/i_fl_rdata completion
module flash_dma_ctrl #(
  parameter int DEST_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int CPU_ADDR_WIDTH = 20,
  parameter logic [23:0] USER_BASE = 24'h100000,
  parameter bit IPL_ENABLE = 1'b1,
  parameter logic [23:0] IPL_SRC = 24'h100000,
  parameter logic [DEST_WIDTH-1:0] IPL_DEST = '0,
  parameter logic [LEN_WIDTH-1:0] IPL_LEN = 16'h3a00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CPU_ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic                      i_cpu_rd_valid,
  output logic                      o_cpu_rd_ready,
  output logic [31:0]               o_cpu_rdata,
  input  logic [23:0]               i_cfg_src,
  input  logic [DEST_WIDTH-1:0]     i_cfg_dst,
  input  logic [LEN_WIDTH-1:0]      i_cfg_len,
  input  logic                      i_cfg_start,
  output logic                      o_dma_busy,
  output logic                      o_dma_done,
  output logic [DEST_WIDTH-1:0]     o_wr_addr,
  output logic [31:0]               o_wr_data,
  output logic [3:0]                o_wr_strobe,
  input  logic                      i_wr_ready,
  output logic                      o_fl_valid,
  output logic                      o_fl_continue,
  output logic [23:0]               o_fl_addr,
  input  logic                      i_fl_ready,
  input  logic [31:0]               i_fl_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_DMA_RD, S_DMA_WR, S_CPU_RD, S_FINISH} state_t;
  state_t r_state, w_next;
  logic [23:0] r_src;
  logic [DEST_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0] r_rem;
  logic r_busy, r_done, r_cpu_ready, r_cont;
  logic [31:0] r_cpu_rdata, r_wr_data;
  logic w_cpu_req;
  logic [23:0] w_cpu_fl_addr;
  // the CPU still holds valid in the cycle its ready pulse is out; that is not a new request
  assign w_cpu_req = i_cpu_rd_valid & ~r_cpu_ready;
  assign w_cpu_fl_addr = USER_BASE + 24'(i_cpu_addr & ~CPU_ADDR_WIDTH'(3));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_cfg_start ? S_ARB : w_cpu_req ? S_CPU_RD : S_IDLE;
      S_ARB:    w_next = r_rem == '0 ? S_FINISH : w_cpu_req ? S_CPU_RD : S_DMA_RD;
      S_DMA_RD: w_next = i_fl_ready ? S_DMA_WR : S_DMA_RD;
      S_DMA_WR: w_next = i_wr_ready ? S_ARB : S_DMA_WR;
      S_CPU_RD: w_next = i_fl_ready ? (r_busy ? S_ARB : S_IDLE) : S_CPU_RD;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IPL_ENABLE ? S_ARB : S_IDLE;
      r_src <= IPL_SRC & ~24'h3;
      r_dst <= IPL_DEST;
      r_rem <= IPL_ENABLE ? IPL_LEN : '0;
      r_busy <= IPL_ENABLE;
      r_done <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_cont <= 1'b0;
      r_cpu_rdata <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == S_FINISH;
      r_cpu_ready <= r_state == S_CPU_RD && i_fl_ready;
      if (r_state == S_IDLE && i_cfg_start) begin
        r_src <= i_cfg_src & ~24'h3;
        r_dst <= i_cfg_dst;
        r_rem <= i_cfg_len;
        r_busy <= 1'b1;
        r_cont <= 1'b0;
      end
      if (r_state == S_FINISH) r_busy <= 1'b0;
      if (r_state == S_DMA_RD && i_fl_ready) begin
        r_wr_data <= i_fl_rdata;
        r_src <= r_src + 24'd4;
        r_cont <= 1'b1;
      end
      if (r_state == S_DMA_WR && i_wr_ready) begin
        r_dst <= r_dst + DEST_WIDTH'(1);
        r_rem <= r_rem - LEN_WIDTH'(1);
      end
      // a CPU read breaks the sequential flash stream
      if (r_state == S_CPU_RD && i_fl_ready) begin
        r_cpu_rdata <= i_fl_rdata;
        r_cont <= 1'b0;
      end
    end
  end
  assign o_fl_valid = r_state == S_DMA_RD || r_state == S_CPU_RD;
  assign o_fl_continue = r_state == S_DMA_RD && r_cont;
  assign o_fl_addr = r_state == S_CPU_RD ? w_cpu_fl_addr : r_src;
  assign o_wr_strobe = {4{r_state == S_DMA_WR}};
  assign o_wr_addr = r_dst;
  assign o_wr_data = r_wr_data;
  assign o_dma_busy = r_busy;
  assign o_dma_done = r_done;
  assign o_cpu_rd_ready = r_cpu_ready;
  assign o_cpu_rdata = r_cpu_rdata;
endmodule

// File: tb/tb_flash_dma_ctrl.sv
// tb_flash_dma_ctrl: directed bench for flash_dma_ctrl with a transaction-level expectation model
module tb_flash_dma_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [19:0] cpu_addr;
  logic cpu_rd_valid, cpu_rd_ready;
  logic [31:0] cpu_rdata;
  logic [23:0] cfg_src;
  logic [15:0] cfg_dst, cfg_len;
  logic cfg_start, dma_busy, dma_done;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_strobe;
  logic wr_ready;
  logic fl_valid, fl_continue, fl_ready;
  logic [23:0] fl_addr;
  logic [31:0] fl_rdata;

  always #5 clk = ~clk;

  flash_dma_ctrl #(.IPL_LEN(16'd4)) dut (
    .clk(clk), .reset(reset),
    .i_cpu_addr(cpu_addr), .i_cpu_rd_valid(cpu_rd_valid), .o_cpu_rd_ready(cpu_rd_ready), .o_cpu_rdata(cpu_rdata),
    .i_cfg_src(cfg_src), .i_cfg_dst(cfg_dst), .i_cfg_len(cfg_len), .i_cfg_start(cfg_start),
    .o_dma_busy(dma_busy), .o_dma_done(dma_done),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_strobe(wr_strobe), .i_wr_ready(wr_ready),
    .o_fl_valid(fl_valid), .o_fl_continue(fl_continue), .o_fl_addr(fl_addr),
    .i_fl_ready(fl_ready), .i_fl_rdata(fl_rdata)
  );

  typedef struct {logic [23:0] a; logic c; logic cpu;} fl_t;
  typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;
  fl_t exp_fl[$], fl_log[$];
  wr_t exp_wr[$], wr_log[$];
  logic [31:0] exp_cpu[$];
  int n_checks = 0, n_errors = 0, done_cnt = 0;
  logic chk_en = 1'b0;
  logic p_fl_done, p_cpu_done, p_busy, p_done;
  logic [31:0] last_cpu;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flash word = its own byte address; replies three cycles after a request appears
  initial begin
    int cnt;
    cnt = 0;
    fl_ready = 1'b0;
    fl_rdata = '0;
    forever begin
      step();
      if (fl_ready || !fl_valid) begin
        fl_ready = 1'b0;
        cnt = 0;
      end else if (cnt == 2) begin
        fl_ready = 1'b1;
        fl_rdata = {8'h0, fl_addr};
      end else cnt++;
    end
  end

  // expected flash requests, writes and CPU data for a transfer; cpu_after inserts a CPU read after that word
  task automatic push_dma(input logic [23:0] src, input logic [15:0] dst, input int len,
                          input int cpu_after, input logic [23:0] cpu_fl);
    fl_t f;
    wr_t w;
    logic c;
    c = 1'b0;
    for (int i = 0; i < len; i++) begin
      f.a = src + 24'(4 * i); f.c = c; f.cpu = 1'b0;
      exp_fl.push_back(f);
      w.a = dst + 16'(i); w.d = {8'h0, f.a};
      exp_wr.push_back(w);
      c = 1'b1;
      if (i == cpu_after) begin
        f.a = cpu_fl; f.c = 1'b0; f.cpu = 1'b1;
        exp_fl.push_back(f);
        exp_cpu.push_back({8'h0, cpu_fl});
        c = 1'b0;
      end
    end
  endtask

  task automatic push_cpu(input logic [19:0] a);
    fl_t f;
    f.a = 24'h100000 + 24'(a & ~20'h3); f.c = 1'b0; f.cpu = 1'b1;
    exp_fl.push_back(f);
    exp_cpu.push_back({8'h0, f.a});
  endtask

  always @(negedge clk) begin
    fl_t f;
    wr_t w;
    if (!chk_en) begin
      p_fl_done = 1'b0; p_cpu_done = 1'b0; p_busy = dma_busy; p_done = 1'b0; last_cpu = '0;
    end else begin
      check("fl_idle_gap", 32'(fl_valid & p_fl_done), 0);
      if (!fl_valid) check("fl_continue_idle", 32'(fl_continue), 0);
      check("cpu_rd_ready_timing", 32'(cpu_rd_ready), 32'(p_cpu_done));
      if (cpu_rd_ready) begin
        check("cpu_rd_expected", 32'(exp_cpu.size() != 0), 1);
        if (exp_cpu.size() != 0) last_cpu = exp_cpu.pop_front();
      end
      check("cpu_rdata", cpu_rdata, last_cpu);
      p_fl_done = fl_valid & fl_ready;
      p_cpu_done = 1'b0;
      if (fl_valid && fl_ready) begin
        check("fl_expected", 32'(exp_fl.size() != 0), 1);
        f.cpu = 1'b0;
        if (exp_fl.size() != 0) begin
          f = exp_fl.pop_front();
          check("fl_addr", 32'(fl_addr), 32'(f.a));
          check("fl_continue", 32'(fl_continue), 32'(f.c));
          p_cpu_done = f.cpu;
        end
        f.a = fl_addr; f.c = fl_continue;
        fl_log.push_back(f);
      end
      check("wr_strobe_legal", 32'(wr_strobe == 4'h0 || wr_strobe == 4'hF), 1);
      if (wr_strobe != 4'h0) begin
        check("no_fl_while_wr", 32'(fl_valid), 0);
        check("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          check("wr_addr", 32'(wr_addr), 32'(exp_wr[0].a));
          check("wr_data", wr_data, exp_wr[0].d);
          if (wr_ready) w = exp_wr.pop_front();
        end
        if (wr_ready) begin
          w.a = wr_addr; w.d = wr_data;
          wr_log.push_back(w);
        end
      end
      if (dma_done) begin
        done_cnt++;
        check("done_busy_fall", 32'({p_busy, dma_busy}), 32'h2);
        check("done_single", 32'(p_done), 0);
      end
      p_busy = dma_busy;
      p_done = dma_done;
    end
  end

  task automatic start_dma(input logic [23:0] s, input logic [15:0] d, input logic [15:0] l);
    cfg_src = s; cfg_dst = d; cfg_len = l; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 500 && !dma_done; n++) step();
    check(name, 32'(dma_done), 1);
    check({name, "_busy"}, 32'(dma_busy), 0);
    step();
  endtask

  task automatic wait_cpu(input string name);
    for (int n = 0; n < 200 && !cpu_rd_ready; n++) step();
    check(name, 32'(cpu_rd_ready), 1);
    cpu_rd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ipl_d [4];
    logic ipl_c [4];
    logic [15:0] wrap_a [3];
    int stall_ok, busy_cycles, d0;
    ipl_d = '{32'h00100000, 32'h00100004, 32'h00100008, 32'h0010000C};
    ipl_c = '{1'b0, 1'b1, 1'b1, 1'b1};
    wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    reset = 1'b1; cpu_addr = '0; cpu_rd_valid = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_start = 1'b0; wr_ready = 1'b1;
    repeat (3) step();
    check("rst_cpu_rd_ready", 32'(cpu_rd_ready), 0);
    check("rst_dma_done", 32'(dma_done), 0);
    check("rst_fl_valid", 32'(fl_valid), 0);
    check("rst_fl_continue", 32'(fl_continue), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_busy", 32'(dma_busy), 1);

    push_dma(24'h100000, 16'h0000, 4, -1, '0);
    chk_en = 1'b1;
    reset = 1'b0;
    wait_done("ipl_done");
    check("ipl_writes", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("ipl_wr_addr", 32'(wr_log[i].a), i);
      check("ipl_wr_data", wr_log[i].d, ipl_d[i]);
      check("ipl_fl_continue", 32'(fl_log[i].c), 32'(ipl_c[i]));
    end
    check("ipl_done_count", done_cnt, 1);

    fl_log.delete(); wr_log.delete();
    cpu_addr = 20'h00013;
    push_cpu(cpu_addr);
    cpu_rd_valid = 1'b1;
    step();
    check("cpu_rd_issue", 32'(fl_valid), 1);
    wait_cpu("cpu_idle_ready");
    check("cpu_idle_rdata", cpu_rdata, 32'h00100010);
    check("cpu_idle_fl_addr", 32'(fl_log[0].a), 32'h100010);
    check("cpu_idle_fl_cont", 32'(fl_log[0].c), 0);
    step();

    fl_log.delete(); wr_log.delete();
    push_dma(24'h200000, 16'hFFFE, 3, -1, '0);
    start_dma(24'h200000, 16'hFFFE, 16'd3);
    wait_done("wrap_done");
    for (int i = 0; i < 3; i++) check("wrap_wr_addr", 32'(wr_log[i].a), 32'(wrap_a[i]));

    fl_log.delete(); wr_log.delete();
    cpu_addr = 20'h00041;
    push_dma(24'h300000, 16'h0010, 3, 1, 24'h100040);
    start_dma(24'h300000, 16'h0010, 16'd3);
    for (int n = 0; n < 200 && !(fl_valid && fl_addr == 24'h300004); n++) step();
    check("ilv_word2_seen", 32'(fl_addr), 32'h300004);
    cpu_rd_valid = 1'b1;
    wait_cpu("ilv_cpu_ready");
    wait_done("ilv_done");
    check("ilv_cpu_fl_addr", 32'(fl_log[2].a), 32'h100040);
    check("ilv_word3_addr", 32'(fl_log[3].a), 32'h300008);
    check("ilv_word3_cont", 32'(fl_log[3].c), 0);
    check("ilv_cpu_rdata", cpu_rdata, 32'h00100040);

    fl_log.delete(); wr_log.delete();
    d0 = done_cnt;
    wr_ready = 1'b0;
    push_dma(24'h400000, 16'h0020, 2, -1, '0);
    start_dma(24'h400000, 16'h0020, 16'd2);
    for (int n = 0; n < 100 && wr_strobe == 4'h0; n++) step();
    check("stall_strobe_seen", 32'(wr_strobe), 32'hF);
    cfg_src = 24'h500000; cfg_dst = 16'h0; cfg_len = 16'd5;
    stall_ok = 0;
    for (int i = 0; i < 10; i++) begin
      cfg_start = (i == 3);
      step();
      if (wr_strobe == 4'hF && !fl_valid && dma_busy) stall_ok++;
    end
    cfg_start = 1'b0;
    check("stall_cycles", stall_ok, 10);
    wr_ready = 1'b1;
    wait_done("stall_done");
    repeat (8) step();
    check("stall_one_done", done_cnt - d0, 1);
    check("stall_fl_drained", exp_fl.size(), 0);
    check("stall_wr_drained", exp_wr.size(), 0);

    wr_log.delete();
    start_dma(24'h700000, 16'h0040, 16'd0);
    busy_cycles = 0;
    for (int n = 0; n < 20 && dma_busy; n++) begin
      busy_cycles++;
      step();
    end
    check("len0_busy_cycles", busy_cycles, 2);
    check("len0_done", 32'(dma_done), 1);
    step();
    check("len0_no_writes", wr_log.size(), 0);

    fl_log.delete(); wr_log.delete();
    push_dma(24'h600000, 16'h0030, 8, -1, '0);
    start_dma(24'h600000, 16'h0030, 16'd8);
    for (int n = 0; n < 500 && wr_log.size() < 2; n++) step();
    check("rst_mid_progress", wr_log.size(), 2);
    for (int n = 0; n < 50 && !fl_valid; n++) step();
    chk_en = 1'b0;
    reset = 1'b1;
    step();
    check("rst_mid_wr_strobe", 32'(wr_strobe), 0);
    check("rst_mid_fl_valid", 32'(fl_valid), 0);
    check("rst_mid_busy", 32'(dma_busy), 1);
    check("rst_mid_cpu_rdata", cpu_rdata, 0);
    exp_fl.delete(); exp_wr.delete(); exp_cpu.delete(); fl_log.delete(); wr_log.delete();
    step();
    push_dma(24'h100000, 16'h0000, 4, -1, '0);
    chk_en = 1'b1;
    reset = 1'b0;
    wait_done("ipl_restart_done");
    check("ipl_restart_fl_addr", 32'(fl_log[0].a), 32'h100000);
    check("ipl_restart_writes", wr_log.size(), 4);
    check("ipl_restart_data0", wr_log[0].d, 32'h00100000);
    check("ipl_restart_addr3", 32'(wr_log[3].a), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end
endmodule
